// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port synchronous data
// memory between NUM_REQ cores. Each access runs IDLE -> ISSUE -> DONE and
// completes with a one-cycle one-hot ack; read data is returned alongside it.
//
// Handshake: a core raises req_in[i] with stable we/addr/wdata and holds them
// until it sees ack_out[i] high for one cycle. In its ack cycle it may drop req
// or keep it high for a new access. A request that is still high in its own
// ack cycle is ignored for that cycle, so a re-request is only considered from
// the following cycle onward.
module dmem_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int REQ_ID_WIDTH    = 2,
  parameter int DATAPATH_WIDTH  = 64,
  parameter int DMEM_ADDR_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_in,
  input  logic [NUM_REQ-1:0]                   we_in,
  input  logic [NUM_REQ*DMEM_ADDR_WIDTH-1:0]   addr_in,
  input  logic [NUM_REQ*DATAPATH_WIDTH-1:0]    wdata_in,
  output logic [NUM_REQ-1:0]                   ack_out,
  output logic [DATAPATH_WIDTH-1:0]            rdata_out,
  output logic                                 mem_en_out,
  output logic                                 mem_we_out,
  output logic [DMEM_ADDR_WIDTH-1:0]           mem_addr_out,
  output logic [DATAPATH_WIDTH-1:0]            mem_wdata_out,
  input  logic [DATAPATH_WIDTH-1:0]            mem_rdata_in,
  output logic                                 busy_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [NUM_REQ-1:0] ONE_HOT_ZERO = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]                  state;
  logic [REQ_ID_WIDTH-1:0]     last_grant;
  logic [REQ_ID_WIDTH-1:0]     grant_id;
  logic                        grant_we;

  logic [NUM_REQ-1:0]          eligible;
  logic [REQ_ID_WIDTH-1:0]     pick;
  logic [REQ_ID_WIDTH-1:0]     idx;
  logic                        found;

  logic [DMEM_ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
  logic [DATAPATH_WIDTH-1:0]   wdata_arr [NUM_REQ];

  // Split the packed request buses into per-core slices.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = addr_in[i*DMEM_ADDR_WIDTH +: DMEM_ADDR_WIDTH];
      wdata_arr[i] = wdata_in[i*DATAPATH_WIDTH +: DATAPATH_WIDTH];
    end
  end

  // Round-robin pick: first eligible core after last_grant, wrapping around.
  always_comb begin
    eligible = req_in & ~ack_out;
    pick     = last_grant;
    idx      = '0;
    found    = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last_grant + REQ_ID_WIDTH'(i);
      if (!found && eligible[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Access sequencer: latch the granted slice, strobe memory, then acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      last_grant    <= REQ_ID_WIDTH'(NUM_REQ - 1);
      grant_id      <= '0;
      grant_we      <= 1'b0;
      ack_out       <= '0;
      rdata_out     <= '0;
      mem_en_out    <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      busy_out      <= 1'b0;
    end else begin
      ack_out <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant_id      <= pick;
            grant_we      <= we_in[pick];
            mem_addr_out  <= addr_arr[pick];
            mem_we_out    <= we_in[pick];
            mem_wdata_out <= wdata_arr[pick];
            mem_en_out    <= 1'b1;
            busy_out      <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Memory captures the access on this edge.
          mem_en_out <= 1'b0;
          mem_we_out <= 1'b0;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          ack_out    <= ONE_HOT_ZERO << grant_id;
          last_grant <= grant_id;
          if (!grant_we) begin
            rdata_out <= mem_rdata_in;
          end
          busy_out   <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          mem_en_out <= 1'b0;
          mem_we_out <= 1'b0;
          busy_out   <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a
// behavioural single-port memory attached to the memory side.
module tb_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_in   = '0;
  logic [N-1:0]    we_in    = '0;
  logic [N*AW-1:0] addr_in  = '0;
  logic [N*DW-1:0] wdata_in = '0;
  logic [N-1:0]    ack_out;
  logic [DW-1:0]   rdata_out;
  logic            mem_en_out;
  logic            mem_we_out;
  logic [AW-1:0]   mem_addr_out;
  logic [DW-1:0]   mem_wdata_out;
  logic [DW-1:0]   mem_rdata_in = '0;
  logic            busy_out;

  dmem_arbiter #(
    .NUM_REQ(N), .REQ_ID_WIDTH(2), .DATAPATH_WIDTH(DW), .DMEM_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .we_in(we_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .ack_out(ack_out),
    .rdata_out(rdata_out), .mem_en_out(mem_en_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in(mem_rdata_in), .busy_out(busy_out)
  );

  // Behavioural synchronous memory: read data appears after the latching edge.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en_out) begin
      if (mem_we_out) mem[mem_addr_out] <= mem_wdata_out;
      else            mem_rdata_in      <= mem[mem_addr_out];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;
  int last_gap  = 0;
  logic [67:0] exp_q [$];      // {ack, rdata}
  logic [72:0] exp_mem_q [$];  // {we, addr, wdata}

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_slice(input int id, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd);
    we_in[id]              = we;
    addr_in[id*AW +: AW]   = addr;
    wdata_in[id*DW +: DW]  = wd;
  endtask

  task automatic wait_ack(input int id);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ack_out[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_cnt++;
      $display("FAIL ack_timeout: core %0d got no ack within 60 cycles", id);
    end
  endtask

  // Hold a request for `count` accesses, dropping req in the final ack cycle.
  task automatic access(input int id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int count);
    set_slice(id, we, addr, wd);
    req_in[id] = 1'b1;
    for (int n = 0; n < count; n++) wait_ack(id);
    req_in[id] = 1'b0;
  endtask

  task automatic push_read(input int id, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic [N-1:0] a;
    a = '0;
    a[id] = 1'b1;
    exp_mem_q.push_back({1'b0, addr, 64'h0});
    exp_q.push_back({a, data});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic prev_en;
    logic prev_ack;
    int en_cyc;
    int ack_cyc;
    logic [67:0] ea;
    logic [72:0] em;
    prev_en  = 1'b0;
    prev_ack = 1'b0;
    en_cyc   = 0;
    ack_cyc  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_en_out) begin
          chk("en_pulse", prev_en, 1'b0);
          chk("busy_issue", busy_out, 1'b1);
          if (exp_mem_q.size() == 0) begin
            check_cnt++;
            $display("FAIL unexpected_access: addr %0h we %0b, none expected", mem_addr_out, mem_we_out);
          end else begin
            em = exp_mem_q.pop_front();
            chk("mem_we", mem_we_out, em[72]);
            chk("mem_addr", mem_addr_out, em[71:64]);
            if (em[72]) chk("mem_wdata", mem_wdata_out, em[63:0]);
          end
          en_cyc = cyc;
        end
        if (ack_out != '0) begin
          chk("ack_pulse", prev_ack, 1'b0);
          chk("ack_latency", cyc - en_cyc, 2);
          chk("busy_at_ack", busy_out, 1'b0);
          if (exp_q.size() == 0) begin
            check_cnt++;
            $display("FAIL unexpected_ack: ack %b, none expected", ack_out);
          end else begin
            ea = exp_q.pop_front();
            chk("ack", ack_out, ea[67:64]);
            chk("rdata", rdata_out, ea[63:0]);
          end
          last_gap = cyc - ack_cyc;
          ack_cyc  = cyc;
        end
      end
      prev_en  = mem_en_out;
      prev_ack = |ack_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 64'h00000000DEADBEEF;
    for (int i = 0; i < 4; i++) mem[8'h20 + i] = 64'hC0DE000000000000 + 64'(i);
    mem[8'h30] = 64'hF000000000000030;
    mem[8'h31] = 64'hF000000000000031;
    mem[8'h33] = 64'hF000000000000033;
    mem[8'h05] = 64'h5555555555555555;

    // Reset with inputs toggling: every output stays zero.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_in   = 4'($urandom_range(0, 15));
      we_in    = 4'($urandom_range(0, 15));
      addr_in  = $urandom();
      wdata_in = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      chk("rst_ack", ack_out, 4'b0);
      chk("rst_rdata", rdata_out, 64'h0);
      chk("rst_en", mem_en_out, 1'b0);
      chk("rst_we", mem_we_out, 1'b0);
      chk("rst_addr", mem_addr_out, 8'h0);
      chk("rst_wdata", mem_wdata_out, 64'h0);
      chk("rst_busy", busy_out, 1'b0);
    end
    req_in = '0; we_in = '0; addr_in = '0; wdata_in = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_en", mem_en_out, 1'b0);
      chk("idle_ack", ack_out, 4'b0);
      chk("idle_busy", busy_out, 1'b0);
    end

    // Single read by core 2.
    push_read(2, 8'h10, 64'h00000000DEADBEEF);
    access(2, 1'b0, 8'h10, 64'h0, 1);
    repeat (3) @(negedge clk);

    // Lone core holding req for two reads: re-request waits one cycle.
    push_read(2, 8'h10, 64'h00000000DEADBEEF);
    push_read(2, 8'h10, 64'h00000000DEADBEEF);
    access(2, 1'b0, 8'h10, 64'h0, 2);
    chk("rerequest_gap", last_gap, 4);
    repeat (3) @(negedge clk);

    // Contention right after reset: order 0,1,2,3, acks 3 cycles apart.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push_read(i, 8'(8'h20 + i), 64'hC0DE000000000000 + 64'(i));
    fork
      access(0, 1'b0, 8'h20, 64'h0, 1);
      access(1, 1'b0, 8'h21, 64'h0, 1);
      access(2, 1'b0, 8'h22, 64'h0, 1);
      access(3, 1'b0, 8'h23, 64'h0, 1);
    join
    chk("contention_gap", last_gap, 3);
    repeat (3) @(negedge clk);

    // Fairness: cores 0,1,3 held high -> 0,1,3,0,1,3.
    for (int r = 0; r < 2; r++) begin
      push_read(0, 8'h30, 64'hF000000000000030);
      push_read(1, 8'h31, 64'hF000000000000031);
      push_read(3, 8'h33, 64'hF000000000000033);
    end
    fork
      access(0, 1'b0, 8'h30, 64'h0, 2);
      access(1, 1'b0, 8'h31, 64'h0, 2);
      access(3, 1'b0, 8'h33, 64'h0, 2);
    join
    chk("fair_gap", last_gap, 3);
    repeat (3) @(negedge clk);

    // Write then read back; rdata holds the last read value across the write.
    exp_mem_q.push_back({1'b1, 8'h7F, 64'h0123456789ABCDEF});
    exp_q.push_back({4'b0010, 64'hF000000000000033});
    push_read(0, 8'h7F, 64'h0123456789ABCDEF);
    access(1, 1'b1, 8'h7F, 64'h0123456789ABCDEF, 1);
    access(0, 1'b0, 8'h7F, 64'h0, 1);
    repeat (3) @(negedge clk);

    // Reset while a core-3 write is in ISSUE: no write, no ack.
    exp_mem_q.push_back({1'b1, 8'h05, 64'hBAD0BAD0BAD0BAD0});
    set_slice(3, 1'b1, 8'h05, 64'hBAD0BAD0BAD0BAD0);
    req_in[3] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_en_out) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check_cnt++;
      $display("FAIL issue_timeout: core 3 write never reached memory");
    end
    #2 reset = 1'b1;
    #1;
    chk("midrst_en", mem_en_out, 1'b0);
    chk("midrst_we", mem_we_out, 1'b0);
    chk("midrst_busy", busy_out, 1'b0);
    chk("midrst_ack", ack_out, 4'b0);
    req_in[3] = 1'b0;
    we_in[3]  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ack", ack_out, 4'b0);
      chk("post_rst_busy", busy_out, 1'b0);
    end
    chk("write_suppressed", mem[8'h05], 64'h5555555555555555);
    push_read(0, 8'h05, 64'h5555555555555555);
    push_read(3, 8'h10, 64'h00000000DEADBEEF);
    fork
      access(0, 1'b0, 8'h05, 64'h0, 1);
      access(3, 1'b0, 8'h10, 64'h0, 1);
    join
    repeat (4) @(negedge clk);

    chk("ack_queue_empty", exp_q.size(), 0);
    chk("mem_queue_empty", exp_mem_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
